// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/load sources, the register file write port and the hazard unit.
interface regfile_wb_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int SEL_WIDTH  = 4,
   parameter int NUM_REGS   = 16
);
   logic                  alu_valid;
   logic                  alu_ready;
   logic [SEL_WIDTH-1:0]  alu_sel;
   logic [DATA_WIDTH-1:0] alu_data;
   logic                  mem_valid;
   logic [SEL_WIDTH-1:0]  mem_sel;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  mem_fifo_full;
   logic                  rf_write_en;
   logic [SEL_WIDTH-1:0]  rf_write_sel;
   logic [DATA_WIDTH-1:0] rf_write_data;
   logic [NUM_REGS-1:0]   busy_mask;
   logic                  err_overflow;

   modport master (
      output alu_valid, alu_sel, alu_data, mem_valid, mem_sel, mem_data,
      input  alu_ready, mem_fifo_full, rf_write_en, rf_write_sel, rf_write_data,
             busy_mask, err_overflow
   );

   modport slave (
      input  alu_valid, alu_sel, alu_data, mem_valid, mem_sel, mem_data,
      output alu_ready, mem_fifo_full, rf_write_en, rf_write_sel, rf_write_data,
             busy_mask, err_overflow
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU results and buffered load returns,
// with load priority, a starvation bound for the ALU, and a pending-write mask for the hazard unit.
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int SEL_WIDTH      = 4,
   parameter int NUM_REGS       = 16,
   parameter int MEM_FIFO_DEPTH = 2,
   parameter int STARVE_LIMIT   = 3
) (
   input logic               clk,
   input logic               rst,
   regfile_wb_arbiter_if.slave wb
);
   localparam int PTR_W = $clog2(MEM_FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {GNT_NONE, GNT_MEM, GNT_ALU} grant_t;

   logic [SEL_WIDTH-1:0]  fifo_sel  [MEM_FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data [MEM_FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr, idx;
   logic [CNT_W-1:0]      count;
   logic [3:0]            starve_cnt;
   grant_t                grant;
   logic                  fifo_full, fifo_empty, pop, push;
   logic [SEL_WIDTH-1:0]  win_sel;
   logic [DATA_WIDTH-1:0] win_data;
   logic [NUM_REGS-1:0]   mask;

   assign fifo_full  = (count == CNT_W'(MEM_FIFO_DEPTH));
   assign fifo_empty = (count == '0);

   always_comb begin
      grant = GNT_NONE;
      if (!rst) begin
         if (!fifo_empty && wb.alu_valid)
            grant = (starve_cnt == 4'(STARVE_LIMIT)) ? GNT_ALU : GNT_MEM;
         else if (!fifo_empty)
            grant = GNT_MEM;
         else if (wb.alu_valid)
            grant = GNT_ALU;
      end
   end

   assign pop  = (grant == GNT_MEM);
   // A pop in the same cycle frees a slot, so a full FIFO can still accept the push.
   assign push = wb.mem_valid && (!fifo_full || pop);

   always_comb begin
      win_sel  = fifo_sel[rd_ptr];
      win_data = fifo_data[rd_ptr];
      if (grant == GNT_ALU) begin
         win_sel  = wb.alu_sel;
         win_data = wb.alu_data;
      end
   end

   assign wb.alu_ready     = (grant == GNT_ALU);
   assign wb.mem_fifo_full = fifo_full;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_sel[wr_ptr]  <= wb.mem_sel;
         fifo_data[wr_ptr] <= wb.mem_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         count            <= '0;
         starve_cnt       <= '0;
         wb.err_overflow  <= 1'b0;
         wb.rf_write_en   <= 1'b0;
         wb.rf_write_sel  <= '0;
         wb.rf_write_data <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wb.mem_valid && !push) wb.err_overflow <= 1'b1;

         if (wb.alu_valid && grant != GNT_ALU) begin
            if (starve_cnt != 4'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
         end else begin
            starve_cnt <= '0;
         end

         wb.rf_write_en <= 1'b0;
         if (grant != GNT_NONE) begin
            wb.rf_write_en   <= (win_sel != '0);
            wb.rf_write_sel  <= win_sel;
            wb.rf_write_data <= win_data;
         end
      end
   end

   always_comb begin
      mask = '0;
      idx  = '0;
      for (int unsigned k = 0; k < MEM_FIFO_DEPTH; k++) begin
         idx = rd_ptr + PTR_W'(k);
         if (CNT_W'(k) < count) mask[fifo_sel[idx]] = 1'b1;
      end
      if (wb.rf_write_en) mask[wb.rf_write_sel] = 1'b1;
      if (wb.alu_valid)   mask[wb.alu_sel]      = 1'b1;
      mask[0] = 1'b0;
   end

   assign wb.busy_mask = mask;
endmodule
